// File: rtl/fft32_frame_loader.sv
// fft32_frame_loader
// Collects a serial stream of complex samples into NPT-sample frames and
// presents each completed frame as one wide word to the first butterfly
// stage. Sample k occupies bits [DW*k +: DW], so sample k and sample k+NPT/2
// sit half a frame apart, as the radix-2 stage expects. Two banks ping-pong:
// one fills while the other holds a complete frame for the consumer.
module fft32_frame_loader #(
    parameter  int DW  = 34,
    parameter  int NPT = 32,
    localparam int FW  = NPT * DW
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [FW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          frame_err,
    output logic [15:0]   frame_cnt
);

    localparam int IDXW = $clog2(NPT);

    logic [FW-1:0]   bank0_r;
    logic [FW-1:0]   bank1_r;
    logic            wr_sel_r;
    logic            rd_sel_r;
    logic [IDXW-1:0] wr_idx_r;
    logic [1:0]      full_r;
    logic            frame_err_r;
    logic [15:0]     frame_cnt_r;

    logic            ready_s;
    logic            accept_s;
    logic            last_slot_s;
    logic            commit_s;
    logic            early_s;
    logic            handoff_s;
    logic            m_valid_s;
    logic [FW-1:0]   m_data_s;
    logic [1:0]      full_next_s;

    // The write bank is only ever full when both banks hold frames, so
    // back-pressure depends on register state alone, never on m_ready.
    assign ready_s     = !full_r[wr_sel_r];
    assign accept_s    = s_valid && ready_s;
    assign last_slot_s = (wr_idx_r == IDXW'(NPT - 1));
    assign commit_s    = accept_s && last_slot_s;
    assign early_s     = accept_s && s_last && !last_slot_s;
    assign m_valid_s   = full_r[rd_sel_r];
    assign handoff_s   = m_valid_s && m_ready;

    // Commit and handoff can coincide; they always address different banks
    // because a commit needs an empty write bank and a handoff a full read bank.
    assign full_next_s[0] = (full_r[0] && !(handoff_s && !rd_sel_r)) || (commit_s && !wr_sel_r);
    assign full_next_s[1] = (full_r[1] && !(handoff_s &&  rd_sel_r)) || (commit_s &&  wr_sel_r);

    // Select the read bank for presentation; its contents cannot change while full.
    always_comb begin
        if (rd_sel_r) begin
            m_data_s = bank1_r;
        end else begin
            m_data_s = bank0_r;
        end
    end

    // Write each accepted sample into its slot of the current write bank.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bank0_r <= '0;
            bank1_r <= '0;
        end else begin
            for (int k = 0; k < NPT; k++) begin
                if (accept_s && (wr_idx_r == IDXW'(k))) begin
                    if (wr_sel_r) begin
                        bank1_r[k*DW +: DW] <= s_data;
                    end else begin
                        bank0_r[k*DW +: DW] <= s_data;
                    end
                end
            end
        end
    end

    // Frame assembly control: slot index, bank pointers, occupancy and status.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_sel_r    <= 1'b0;
            rd_sel_r    <= 1'b0;
            wr_idx_r    <= '0;
            full_r      <= 2'b00;
            frame_err_r <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            full_r      <= full_next_s;
            // A missing s_last on slot NPT-1 still commits; an early s_last
            // drops the partial frame. Both are reported as framing errors.
            frame_err_r <= (commit_s && !s_last) || early_s;
            if (commit_s) begin
                wr_sel_r    <= !wr_sel_r;
                wr_idx_r    <= '0;
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else if (early_s) begin
                wr_idx_r    <= '0;
            end else if (accept_s) begin
                wr_idx_r    <= wr_idx_r + IDXW'(1);
            end
            if (handoff_s) begin
                rd_sel_r <= !rd_sel_r;
            end
        end
    end

    assign s_ready   = ready_s;
    assign m_valid   = m_valid_s;
    assign m_data    = m_data_s;
    assign frame_err = frame_err_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fft32_frame_loader.sv
// Testbench for fft32_frame_loader: a frame-level reference model (a queue of
// completed frames plus the partial frame being collected) predicts every
// output each cycle; table rows and hand-written sequences drive the corners.
module tb_fft32_frame_loader;

    localparam int DW  = 34;
    localparam int NPT = 32;
    localparam int FW  = NPT * DW;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [DW-1:0] s_data    = '0;
    logic          s_valid   = 1'b0;
    logic          s_last    = 1'b0;
    logic          s_ready;
    logic [FW-1:0] m_data;
    logic          m_valid;
    logic          m_ready   = 1'b0;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    always #5 sys_clk = ~sys_clk;

    fft32_frame_loader dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    // Reference model state
    logic [DW-1:0] part_q[$];
    logic [FW-1:0] fq[$];
    logic [15:0]   mcnt;
    bit            merr;
    bit            last_acc;

    int n_chk  = 0;
    int n_pass = 0;
    int dut_hs, dut_err, dut_stall;

    typedef struct {
        int nsamp;
        int early_at;
        bit drop_last;
        int exp_frames;
        int exp_errs;
        int exp_hs;
        int exp_stalls;
    } row_t;
    row_t rows[4];

    function automatic logic [DW-1:0] mk(int k);
        logic [16:0] re;
        logic [16:0] im;
        re = 17'(k);
        im = 17'(-k);
        return {re, im};
    endfunction

    function automatic logic [DW-1:0] slot(int k);
        return m_data[k*DW +: DW];
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_frame(string nm, logic [FW-1:0] exp);
        int bad;
        logic [DW-1:0] e;
        bad = -1;
        for (int k = NPT - 1; k >= 0; k--) begin
            e = exp[k*DW +: DW];
            if (slot(k) !== e) bad = k;
        end
        n_chk++;
        if (bad < 0) n_pass++;
        else begin
            e = exp[bad*DW +: DW];
            $display("FAIL %s slot %0d: got %0h expected %0h", nm, bad, slot(bad), e);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic tick();
        bit rdy;
        logic [FW-1:0] f;
        rdy = (fq.size() < 2);
        if (m_valid && m_ready) dut_hs++;
        if (s_valid && !s_ready) dut_stall++;
        merr = 1'b0;
        if (fq.size() > 0 && m_ready) f = fq.pop_front();
        last_acc = s_valid && rdy;
        if (last_acc) begin
            part_q.push_back(s_data);
            if (part_q.size() == NPT) begin
                f = '0;
                for (int k = 0; k < NPT; k++) f[k*DW +: DW] = part_q[k];
                fq.push_back(f);
                mcnt = mcnt + 16'd1;
                merr = !s_last;
                part_q.delete();
            end else if (s_last) begin
                part_q.delete();
                merr = 1'b1;
            end
        end
        @(posedge sys_clk);
        #1;
        if (frame_err) dut_err++;
        chk("s_ready", 32'(s_ready), 32'(fq.size() < 2));
        chk("m_valid", 32'(m_valid), 32'(fq.size() > 0));
        chk("frame_err", 32'(frame_err), 32'(merr));
        chk("frame_cnt", 32'(frame_cnt), 32'(mcnt));
        if (fq.size() > 0) chk_frame("m_data", fq[0]);
    endtask

    task automatic send(logic [DW-1:0] d, bit l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        last_acc = 1'b0;
        for (int t = 0; t < 100 && !last_acc; t++) tick();
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Asynchronous reset asserted away from the clock edge.
    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        sys_rst_n = 1'b0;
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        part_q.delete();
        fq.delete();
        mcnt = 16'd0;
        merr = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int p;
        bit l;
        logic [63:0] r64;

        rows[0] = '{nsamp: 32, early_at: -1, drop_last: 1'b0, exp_frames: 1, exp_errs: 0, exp_hs: 1, exp_stalls: 0};
        rows[1] = '{nsamp: 96, early_at: -1, drop_last: 1'b0, exp_frames: 3, exp_errs: 0, exp_hs: 3, exp_stalls: 0};
        rows[2] = '{nsamp: 42, early_at:  9, drop_last: 1'b0, exp_frames: 1, exp_errs: 1, exp_hs: 1, exp_stalls: 0};
        rows[3] = '{nsamp: 32, early_at: -1, drop_last: 1'b1, exp_frames: 1, exp_errs: 1, exp_hs: 1, exp_stalls: 0};

        mcnt = 16'd0;
        #1;
        do_reset();

        // Table-driven streaming scenarios with m_ready held high
        for (int r = 0; r < 4; r++) begin
            do_reset();
            m_ready = 1'b1;
            dut_hs = 0; dut_err = 0; dut_stall = 0;
            p = 0;
            for (int i = 0; i < rows[r].nsamp; i++) begin
                l = (i == rows[r].early_at) || (p == NPT - 1 && !rows[r].drop_last);
                if (i == rows[r].early_at || p == NPT - 1) p = 0;
                else p++;
                send(mk(i), l);
            end
            for (int t = 0; t < 4; t++) tick();
            chk($sformatf("row%0d_frame_cnt", r), 32'(frame_cnt), 32'(rows[r].exp_frames));
            chk($sformatf("row%0d_errs", r), 32'(dut_err), 32'(rows[r].exp_errs));
            chk($sformatf("row%0d_handshakes", r), 32'(dut_hs), 32'(rows[r].exp_hs));
            chk($sformatf("row%0d_stalls", r), 32'(dut_stall), 32'(rows[r].exp_stalls));
        end

        // Both banks fill while the consumer stalls, then drain in order
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 2 * NPT; i++) send(mk(i), (i % NPT) == NPT - 1);
        chk("stall_s_ready_low", 32'(s_ready), 32'd0);
        chk("stall_slot0", 32'(slot(0)), 32'(mk(0)));
        chk("stall_slot31", 32'(slot(31)), 32'(mk(31)));
        s_valid = 1'b1;
        s_data  = mk(999);
        for (int t = 0; t < 5; t++) tick();
        chk("stall_held_slot0", 32'(slot(0)), 32'(mk(0)));
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("drain_frame1_slot0", 32'(slot(0)), 32'(mk(NPT)));
        chk("drain_s_ready_high", 32'(s_ready), 32'd1);
        tick();
        chk("drain_m_valid_low", 32'(m_valid), 32'd0);

        // Reset while one frame is pending and the next is part-filled
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < NPT + 20; i++) send(mk(i), (i % NPT) == NPT - 1);
        chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < NPT; i++) send(mk(100 + i), i == NPT - 1);
        chk("post_rst_slot5", 32'(slot(5)), 32'(mk(105)));
        for (int t = 0; t < 3; t++) tick();
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            r64 = {$urandom, $urandom};
            s_data  = DW'(r64);
            s_valid = ($urandom_range(0, 3) != 0);
            if (part_q.size() == NPT - 1) s_last = ($urandom_range(0, 5) != 0);
            else s_last = ($urandom_range(0, 29) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int t = 0; t < 4; t++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft32_frame_loader.md
Name: fft32_frame_loader

Overview:
- Input stage directly upstream of the 32-point radix-2 first-stage butterfly array. Collects a serial stream of 34-bit complex samples into 32-sample frames and presents each frame as one 1088-bit word.
- Frame layout: sample k (natural order) sits at bits [34k+33:34k], which pairs sample k with sample k+16 for the butterfly.
- Ping-pong double buffering lets one frame fill while the previous frame waits for the consumer.

Parameters:
- DW, 34, complex sample width: real part in [DW-1:DW/2], imag part in [DW/2-1:0], both two's complement.
- NPT, 32, samples per frame (power of two).
- FW, NPT*DW (1088), output frame width; derived, do not override.

Ports:
- sys_clk  in  1  single clock; all state changes on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- s_data  in  DW  input sample.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the last sample of a frame; qualified by s_valid&&s_ready.
- s_ready  out  1  loader can accept a sample this cycle.
- m_data  out  FW  assembled frame.
- m_valid  out  1  m_data holds a complete frame.
- m_ready  in  1  downstream accepts the frame.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  16  count of frames committed, wrapping.

Behaviour:
- Reset (async assert, sync release): both banks cleared to 0, wr_sel=0, rd_sel=0, wr_idx=0, full[1:0]=0, m_valid=0, m_data=0, frame_err=0, frame_cnt=0. s_ready is 1 in the first cycle after release.
- Reset asserted mid-frame or mid-handoff discards all partial and full frames. No output transaction survives.
- s_ready = !full[wr_sel], combinational from registers only. It does not depend on m_ready.
- Sample accept (s_valid && s_ready): write s_data to bank[wr_sel] slot wr_idx, then wr_idx++.
- Commit (accepted sample has wr_idx==NPT-1):
  - set full[wr_sel], toggle wr_sel, set wr_idx=0, increment frame_cnt (wraps at 16'hFFFF→0).
  - If s_last=0 on this sample, the frame is still committed and frame_err pulses.
- Early s_last (accepted sample has s_last=1 and wr_idx<NPT-1):
  - partial frame discarded, wr_idx=0, wr_sel unchanged, full unchanged.
  - frame_err pulses; frame_cnt unchanged.
- m_valid = full[rd_sel]. m_data = bank[rd_sel], held stable while m_valid is high and m_ready is low.
- Handoff (m_valid && m_ready): clear full[rd_sel] and toggle rd_sel.
- Latency: the cycle after a sample-31 accept, m_valid=1 and m_data holds the frame, provided the other bank is empty.
- A commit and a handoff in the same cycle are both applied; they always target different banks.
- Both banks full: s_ready=0, and incoming samples are held off, never dropped.
- Once the read bank frees, s_ready returns high on the next cycle.
- Sustained throughput is one sample per cycle when m_ready is asserted at least once per NPT cycles.
- The m_data value is undefined as a frame when m_valid=0; the checker ignores it.
- frame_err is registered and is high for exactly one cycle per error event.

Test Plan:
- Reset, then stream samples 0..31 with s_data={re=k, im=-k}, s_last on 31, m_ready=1 → m_valid high for 1 cycle after the accept. Slot k = {17'dk, -17'dk}. frame_cnt=1, frame_err never high.
- Continuous 3 frames back to back with m_ready=1 → s_ready stays 1 throughout. Three m_valid handshakes, frame_cnt=3.
- m_ready=0 while streaming 64 samples → s_ready drops the cycle after sample 63 commits. m_data stays equal to frame 0. Raise m_ready → frame 0 then frame 1 delivered in order, and s_ready returns high.
- s_last on sample 9 → frame_err pulse one cycle. The next 32 samples form a clean frame whose slot 0 holds the 11th sample sent, and frame_cnt increments by 1 only.
- Sample 31 sent without s_last → frame committed, frame_err pulse, frame_cnt increments.
- Assert sys_rst_n=0 asynchronously after 20 samples of frame 1 while frame 0 is pending → m_valid=0 and frame_err=0 immediately. After release, a fresh 32-sample frame is delivered correctly with frame_cnt=1.
